fp_sqrt_stream: RTL and testbench

- Fixed-point square root, digit-by-digit (restoring, one result bit per digit). Successor to the single-digit `go`/`done` sqrt unit.
- Adds configurable digits per cycle, selectable rounding, signed-input error detection, a remainder output, and a ready/valid handshake on both sides with output hold under backpressure.
- Sits in the fixed-point math primitive library and is instantiated by generated datapaths.

---
 rtl/fp_sqrt_pkg.sv | 21 ++
 rtl/fp_sqrt_digit.sv | 36 +++
 rtl/fp_sqrt_stream.sv | 143 ++++++++++++++
 tb/tb_fp_sqrt_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and elaboration helpers for the fixed-point square root stream unit.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int RND_TRUNC   = 0;
  localparam int RND_NEAREST = 1;

  function automatic int calc_iterations(input int width, input int frac_width);
    return (width + frac_width) / 2;
  endfunction

  function automatic int calc_steps(input int iterations, input int digits_per_cycle);
    return (iterations + digits_per_cycle - 1) / digits_per_cycle;
  endfunction

endpackage

// File: rtl/fp_sqrt_digit.sv
// One restoring square-root digit: bring in two radicand bits, trial-subtract, emit one root bit.
module fp_sqrt_digit #(
  parameter int WIDTH = 32,
  parameter int XW    = 48
) (
  input  logic             en_i,
  input  logic [WIDTH+1:0] acc_i,
  input  logic [XW-1:0]    x_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH+1:0] acc_o,
  output logic [XW-1:0]    x_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] acc_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] tmp;
  logic             fits;

  // Shifting before the subtract leaves acc holding the exact remainder after the last digit.
  always_comb begin
    acc_sh = (acc_i << 2) | {{WIDTH{1'b0}}, x_i[XW-1 -: 2]};
    trial  = {q_i, 2'b01};
    tmp    = acc_sh - trial;
    fits   = (acc_sh >= trial);
    acc_o  = acc_i;
    x_o    = x_i;
    q_o    = q_i;
    if (en_i) begin
      acc_o = fits ? tmp : acc_sh;
      q_o   = (q_i << 1) | {{(WIDTH-1){1'b0}}, fits};
      x_o   = x_i << 2;
    end
  end

endmodule

// File: rtl/fp_sqrt_stream.sv
// Streaming fixed-point square root with ready/valid on both sides and a held result.
module fp_sqrt_stream
  import fp_sqrt_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int INT_WIDTH        = 16,
  parameter int FRAC_WIDTH       = 16,
  parameter int DIGITS_PER_CYCLE = 1,
  parameter int ROUND_NEAREST    = 0,
  parameter int SIGNED           = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH+1:0] rem,
  output logic             error
);

  localparam int ITERATIONS  = calc_iterations(WIDTH, FRAC_WIDTH);
  localparam int STEPS       = calc_steps(ITERATIONS, DIGITS_PER_CYCLE);
  localparam int LAST_DIGITS = ITERATIONS - (STEPS - 1) * DIGITS_PER_CYCLE;
  localparam int XW          = WIDTH + FRAC_WIDTH;
  localparam int CW          = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (WIDTH != INT_WIDTH + FRAC_WIDTH || ((WIDTH + FRAC_WIDTH) % 2) != 0 ||
      FRAC_WIDTH >= WIDTH || DIGITS_PER_CYCLE < 1 || DIGITS_PER_CYCLE > ITERATIONS ||
      (ROUND_NEAREST != RND_TRUNC && ROUND_NEAREST != RND_NEAREST)) begin : g_bad_param
    $error("fp_sqrt_stream: illegal parameter combination");
  end

  state_e           state_q;
  logic [WIDTH+1:0] acc_q;
  logic [XW-1:0]    x_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    step_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH+1:0] rem_q;
  logic             err_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [WIDTH+1:0] acc_d [DIGITS_PER_CYCLE+1];
  logic [XW-1:0]    x_d   [DIGITS_PER_CYCLE+1];
  logic [WIDTH-1:0] q_d   [DIGITS_PER_CYCLE+1];

  assign acc_d[0] = acc_q;
  assign x_d[0]   = x_q;
  assign q_d[0]   = q_q;

  // Digits beyond the remainder count are bypassed on the final, partial step.
  for (genvar g = 0; g < DIGITS_PER_CYCLE; g++) begin : g_digit
    localparam bit ALWAYS_ON = (g < LAST_DIGITS);
    fp_sqrt_digit #(.WIDTH(WIDTH), .XW(XW)) u_digit (
      .en_i  (ALWAYS_ON || (step_q != LAST_STEP)),
      .acc_i (acc_d[g]),
      .x_i   (x_d[g]),
      .q_i   (q_d[g]),
      .acc_o (acc_d[g+1]),
      .x_o   (x_d[g+1]),
      .q_o   (q_d[g+1])
    );
  end

  function automatic logic [WIDTH-1:0] round_root(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH+1:0] r);
    logic [WIDTH:0] sum;
    if (ROUND_NEAREST != RND_NEAREST) return q;
    sum = {1'b0, q} + {{WIDTH{1'b0}}, (r > {2'b00, q})};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      x_q         <= '0;
      q_q         <= '0;
      step_q      <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (SIGNED != 0 && in[WIDTH-1]) begin
              out_q       <= '0;
              rem_q       <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              acc_q   <= '0;
              x_q     <= {in, {FRAC_WIDTH{1'b0}}};
              q_q     <= '0;
              step_q  <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d[DIGITS_PER_CYCLE];
          x_q   <= x_d[DIGITS_PER_CYCLE];
          q_q   <= q_d[DIGITS_PER_CYCLE];
          if (step_q == LAST_STEP) begin
            out_q       <= round_root(q_d[DIGITS_PER_CYCLE], acc_d[DIGITS_PER_CYCLE]);
            rem_q       <= acc_d[DIGITS_PER_CYCLE];
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            step_q <= step_q + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign rem       = rem_q;
  assign error     = err_q;

endmodule

// File: tb/tb_fp_sqrt_stream.sv
// Bench for fp_sqrt_stream across several digit/rounding/sign configurations.
module tb_fp_sqrt_stream;

  localparam int N = 6;
  localparam int DPC [N] = '{1, 5, 5, 4, 4, 3};
  localparam int RN  [N] = '{0, 0, 1, 1, 0, 1};
  localparam int SG  [N] = '{0, 0, 0, 0, 0, 1};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic        error     [N];
  logic [31:0] din       [N];
  logic [31:0] dout      [N];
  logic [33:0] rem       [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    fp_sqrt_stream #(
      .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16),
      .DIGITS_PER_CYCLE(DPC[g]), .ROUND_NEAREST(RN[g]), .SIGNED(SG[g])
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in        (din[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out       (dout[g]),
      .rem       (rem[g]),
      .error     (error[g])
    );
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int steps_of(input int k);
    return (24 + DPC[k] - 1) / DPC[k];
  endfunction

  // Reference: integer square root of in * 2^FRAC by bisection, then the rounding rule.
  function automatic void model(input int k, input logic [31:0] v, output logic [31:0] o,
                                output logic [33:0] r, output logic e);
    longint unsigned big, lo, hi, mid, q, rr;
    if (SG[k] != 0 && v[31]) begin
      o = '0; r = '0; e = 1'b1;
      return;
    end
    big = {16'h0, v, 16'h0};
    lo = 0;
    hi = 64'h100_0000;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= big) lo = mid;
      else hi = mid;
    end
    q  = lo;
    rr = big - q * q;
    if (RN[k] != 0 && rr > q) q = q + 1;
    if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
    o = q[31:0];
    r = rr[33:0];
    e = 1'b0;
  endfunction

  task automatic run_op(input int k, input logic [31:0] v, input int backp,
                        input logic [31:0] eo, input logic [33:0] er, input logic ee,
                        input string tag);
    int w;
    int lat;
    logic [31:0] o0;
    logic [33:0] r0;
    w = 0;
    while (!in_ready[k] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready[k]) begin
      check({tag, " in_ready_timeout"}, 68'd0, 68'd1);
      return;
    end
    in_valid[k] = 1'b1;
    din[k]      = v;
    @(negedge clk);
    in_valid[k] = 1'b0;
    din[k]      = $urandom;
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 68'(lat), 68'(ee ? 0 : steps_of(k)));
    check({tag, " out"}, 68'(dout[k]), 68'(eo));
    check({tag, " rem"}, 68'(rem[k]), 68'(er));
    check({tag, " error"}, 68'(error[k]), 68'(ee));
    o0 = dout[k];
    r0 = rem[k];
    for (int i = 0; i < backp; i++) begin
      @(negedge clk);
      check({tag, " hold_data"}, {2'b00, o0, r0}, {2'b00, dout[k], rem[k]});
      check({tag, " hold_ctl"}, 68'({out_valid[k], in_ready[k]}), 68'(2'b10));
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, " release"}, 68'({out_valid[k], in_ready[k]}), 68'(2'b01));
  endtask

  typedef struct {
    int          k;
    logic [31:0] v;
    int          backp;
    logic [31:0] eo;
    logic [33:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] v, eo;
    logic [33:0] er;
    logic        ee;
    logic        seen;

    tbl[0] = '{0, 32'h0004_0000, 10, 32'h0002_0000, 34'd0,        1'b0};
    tbl[1] = '{1, 32'h0002_0000, 0,  32'h0001_6A09, 34'd166831,   1'b0};
    tbl[2] = '{2, 32'h0002_0000, 2,  32'h0001_6A0A, 34'd166831,   1'b0};
    tbl[3] = '{3, 32'hFFFF_FFFF, 0,  32'h0100_0000, 34'h1FE_FFFF, 1'b0};
    tbl[4] = '{4, 32'hFFFF_FFFF, 1,  32'h00FF_FFFF, 34'h1FE_FFFF, 1'b0};
    tbl[5] = '{5, 32'h8000_0000, 3,  32'h0000_0000, 34'd0,        1'b1};
    tbl[6] = '{5, 32'h0009_0000, 0,  32'h0003_0000, 34'd0,        1'b0};
    tbl[7] = '{0, 32'h0000_0000, 0,  32'h0000_0000, 34'd0,        1'b0};

    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      din[i]       = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_ctl%0d", i), 68'({in_ready[i], out_valid[i], error[i]}), 68'd0);
      check($sformatf("reset_data%0d", i), {2'b00, dout[i], rem[i]}, 68'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].k, tbl[i].v, tbl[i].backp, tbl[i].eo, tbl[i].er, tbl[i].ee,
             $sformatf("vec%0d", i));

    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 6; j++) begin
        v = $urandom;
        if (j == 0) v = 32'hFFFF_FFFF;
        model(k, v, eo, er, ee);
        run_op(k, v, $urandom_range(0, 3), eo, er, ee, $sformatf("rnd%0d_%0d", k, j));
      end
    end

    // Reset in the middle of a computation must abort it silently.
    while (!in_ready[0]) @(negedge clk);
    in_valid[0] = 1'b1;
    din[0]      = 32'h0009_0000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_ctl", 68'({in_ready[0], out_valid[0], error[0]}), 68'd0);
    check("midreset_data", {2'b00, dout[0], rem[0]}, 68'd0);
    check("midreset_other", 68'(in_ready[1]), 68'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("midreset_no_valid", 68'(seen), 68'd0);
    run_op(0, 32'h0009_0000, 0, 32'h0003_0000, 34'd0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
